// File: rtl/card_pkg.sv
// Shared card-board types and constants, also imported by the card comparator.
// Latency: none (definitions only).
// Backpressure: none.
package card_pkg;

  localparam int NUM_CARDS = 36;
  localparam int NUM_PAIRS = 18;
  localparam int DATA_W    = 5;
  localparam int ADDR_W    = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [DATA_W-1:0] card_t;
  typedef logic [ADDR_W-1:0] pos_t;

  // All-ones marks a removed card, or any read that has no valid card behind it
  localparam card_t EMPTY_CARD = 5'h1F;

  typedef enum logic [1:0] {IDLE, FILL, SHUFFLE, DONE} board_state_t;

  // One step of the 16-bit right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (mask 16'hB400, shift right) driving the shuffle.
// Latency: new value visible one cycle after load/step.
// Backpressure: none; load takes priority over step.
module lfsr16
  import card_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = card_pkg::LFSR_SEED
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] q
);

  // Load a new seed, otherwise advance one step when requested
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/card_board_shuffler.sv
// Fills a 36-entry card board with 18 pairs, Fisher-Yates shuffles it, then serves reads/clears.
// Latency: ready rises 71 cycles after start is sampled; rd_data is combinational.
// Backpressure: none; start is ignored while busy, clears are ignored unless ready.
module card_board_shuffler #(
  parameter int          NUM_CARDS = card_pkg::NUM_CARDS,
  parameter int          DATA_W    = card_pkg::DATA_W,
  parameter int          ADDR_W    = card_pkg::ADDR_W,
  parameter logic [15:0] LFSR_SEED = card_pkg::LFSR_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       seed_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clear_en,
  input  logic [ADDR_W-1:0] clear_addr,
  output logic              busy,
  output logic              ready,
  output logic [5:0]        cards_left,
  output logic              all_cleared
);
  import card_pkg::*;

  localparam logic [DATA_W-1:0] EMPTY    = {DATA_W{1'b1}};
  localparam logic [ADDR_W-1:0] NUM_POS  = ADDR_W'(NUM_CARDS);
  localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(NUM_CARDS - 1);
  localparam logic [ADDR_W-1:0] ONE_POS  = ADDR_W'(1);

  board_state_t        state;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   board [NUM_CARDS];

  logic [15:0]         lfsr_q;
  logic [15:0]         load_val;
  logic                lfsr_load;
  logic                lfsr_step;

  logic [ADDR_W-1:0]   idx_p1;
  logic [ADDR_W+7:0]   prod;
  logic [ADDR_W-1:0]   swap_j;
  logic                clear_ok;

  // A new shuffle may only begin when no fill/shuffle is running
  assign lfsr_load = start && ((state == IDLE) || (state == DONE));
  assign load_val  = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
  assign lfsr_step = (state == SHUFFLE);

  lfsr16 #(
    .RESET_VAL (LFSR_SEED)
  ) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .load     (lfsr_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // Swap partner: scale the low LFSR byte into 0..idx without a divider
  always_comb begin
    idx_p1 = idx + ONE_POS;
    prod   = {{ADDR_W{1'b0}}, lfsr_q[7:0]} * {8'h00, idx_p1};
    swap_j = prod[ADDR_W+7:8];
  end

  // A clear only counts when it actually removes a live card
  always_comb begin
    clear_ok = 1'b0;
    if (ready && clear_en && (clear_addr < NUM_POS)) begin
      clear_ok = (board[clear_addr] != EMPTY);
    end
  end

  // Board FSM: fill pairs, shuffle one swap per cycle, then serve clears
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      cards_left <= '0;
      for (int k = 0; k < NUM_CARDS; k++) begin
        board[k] <= EMPTY;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          // start outranks a same-cycle clear; the board is rebuilt anyway
          if (start) begin
            state      <= FILL;
            idx        <= '0;
            busy       <= 1'b1;
            ready      <= 1'b0;
            cards_left <= '0;
          end else if (clear_ok) begin
            board[clear_addr] <= EMPTY;
            cards_left        <= cards_left - 6'd1;
          end
        end
        FILL: begin
          board[idx] <= DATA_W'(idx >> 1);
          if (idx == LAST_POS) begin
            state <= SHUFFLE;
          end else begin
            idx <= idx + ONE_POS;
          end
        end
        SHUFFLE: begin
          board[idx]    <= board[swap_j];
          board[swap_j] <= board[idx];
          if (idx == ONE_POS) begin
            state      <= DONE;
            busy       <= 1'b0;
            ready      <= 1'b1;
            cards_left <= 6'(NUM_CARDS);
          end else begin
            idx <= idx - ONE_POS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data     = (ready && (rd_addr < NUM_POS)) ? board[rd_addr] : EMPTY;
  assign all_cleared = ready && (cards_left == 6'd0);

endmodule

// File: tb/tb_card_board_shuffler.sv
// Scoreboard bench for card_board_shuffler: stimulus queues expectations, a monitor compares.
module tb_card_board_shuffler;

  localparam int EMPTY     = 31;
  localparam int K_RD      = 0;
  localparam int K_READY   = 1;
  localparam int K_BUSY    = 2;
  localparam int K_LEFT    = 3;
  localparam int K_ALLCLR  = 4;
  localparam int K_LAT     = 5;
  localparam int K_BUSYCNT = 6;
  localparam int K_HIST    = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  logic [5:0]  rd_addr = 6'd0;
  logic [4:0]  rd_data;
  logic        clear_en = 1'b0;
  logic [5:0]  clear_addr = 6'd0;
  logic        busy;
  logic        ready;
  logic [5:0]  cards_left;
  logic        all_cleared;

  int    errors = 0;
  int    checks = 0;
  int    exp_q[$];
  string name_q[$];
  logic  obs_vld = 1'b0;
  int    obs_kind = 0;
  int    lat_meas = 0;
  int    busy_cnt = 0;
  int    hist_bad = 0;
  int    model[36];

  always #5 clock = ~clock;

  card_board_shuffler dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .seed_in     (seed_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clear_en    (clear_en),
    .clear_addr  (clear_addr),
    .busy        (busy),
    .ready       (ready),
    .cards_left  (cards_left),
    .all_cleared (all_cleared)
  );

  // Monitor: on each flagged observation, pop the oldest expectation and compare
  always @(negedge clock) begin
    if (obs_vld) begin
      int    act;
      int    ex;
      string nm;
      case (obs_kind)
        K_RD:      act = int'(rd_data);
        K_READY:   act = int'(ready);
        K_BUSY:    act = int'(busy);
        K_LEFT:    act = int'(cards_left);
        K_ALLCLR:  act = int'(all_cleared);
        K_LAT:     act = lat_meas;
        K_BUSYCNT: act = busy_cnt;
        K_HIST:    act = hist_bad;
        default:   act = -1;
      endcase
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got %0d with nothing expected", act);
      end else begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act != ex) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", nm, act, ex);
        end
      end
    end
  end

  task automatic chk(input int kind, input int addr, input int ex, input string nm);
    rd_addr  = 6'(addr);
    obs_kind = kind;
    exp_q.push_back(ex);
    name_q.push_back(nm);
    obs_vld  = 1'b1;
    @(negedge clock);
    #1;
    obs_vld  = 1'b0;
  endtask

  // Reference board: pair fill followed by the LFSR-driven Fisher-Yates pass
  task automatic build_model(input logic [15:0] seed);
    logic [15:0] l;
    int j;
    int t;
    l = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < 36; k++) model[k] = k / 2;
    for (int i = 35; i >= 1; i--) begin
      j = (int'(l[7:0]) * (i + 1)) / 256;
      t = model[i];
      model[i] = model[j];
      model[j] = t;
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  task automatic check_board(input string tag);
    for (int p = 0; p < 36; p++) chk(K_RD, p, model[p], $sformatf("%s_pos%0d", tag, p));
  endtask

  // Count values 0..17 not present exactly twice, plus any non-card entries
  task automatic check_hist();
    int h[18];
    int v;
    int bad;
    bad = 0;
    for (int k = 0; k < 18; k++) h[k] = 0;
    for (int p = 0; p < 36; p++) begin
      rd_addr = 6'(p);
      #1;
      v = int'(rd_data);
      if (v < 18) h[v]++;
      else bad++;
    end
    for (int k = 0; k < 18; k++) if (h[k] != 2) bad++;
    hist_bad = bad;
    chk(K_HIST, 0, 0, "histogram");
  endtask

  task automatic pulse_clear(input int a);
    @(posedge clock);
    #1;
    clear_en   = 1'b1;
    clear_addr = 6'(a);
    @(posedge clock);
    #1;
    clear_en   = 1'b0;
  endtask

  // Issue start; optionally a second start at cycle extra_at, reset at cycle rst_at,
  // or a clear alongside the start. Measures cycles to ready and busy-high cycles.
  task automatic run_start(input logic [15:0] seed, input int extra_at, input int rst_at,
                           input int clr_with_start);
    @(posedge clock);
    #1;
    start   = 1'b1;
    seed_in = seed;
    if (clr_with_start >= 0) begin
      clear_en   = 1'b1;
      clear_addr = 6'(clr_with_start);
    end
    @(posedge clock);
    #1;
    start    = 1'b0;
    clear_en = 1'b0;
    seed_in  = 16'h5555;
    busy_cnt = busy ? 1 : 0;
    lat_meas = 999;
    for (int n = 1; n <= 200; n++) begin
      if (n == extra_at) start = 1'b1;
      if (n == rst_at) reset = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        return;
      end
      if (busy) busy_cnt++;
      if (ready) begin
        lat_meas = n;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    chk(K_READY, 0, 0, "rst_ready");
    chk(K_BUSY, 0, 0, "rst_busy");
    chk(K_LEFT, 0, 0, "rst_cards_left");
    chk(K_ALLCLR, 0, 0, "rst_all_cleared");
    for (int a = 0; a < 64; a++) chk(K_RD, a, EMPTY, $sformatf("rst_rd%0d", a));

    // Clear outside DONE is ignored
    pulse_clear(0);
    chk(K_LEFT, 0, 0, "idle_clear_left");

    // First shuffle, seed 1: timing, contents, histogram
    build_model(16'h0001);
    run_start(16'h0001, 0, 0, -1);
    chk(K_LAT, 0, 71, "latency_s1");
    chk(K_BUSYCNT, 0, 71, "busy_cycles_s1");
    chk(K_BUSY, 0, 0, "busy_done_s1");
    chk(K_LEFT, 0, 36, "cards_left_s1");
    chk(K_ALLCLR, 0, 0, "all_cleared_s1");
    check_hist();
    check_board("s1");
    chk(K_RD, 40, EMPTY, "rd_out_of_range");

    // Determinism and seed handling
    run_start(16'h0001, 0, 0, -1);
    check_board("s1_repeat");
    build_model(16'h1234);
    run_start(16'h1234, 0, 0, -1);
    check_board("s1234");
    build_model(16'hACE1);
    run_start(16'h0000, 0, 0, -1);
    check_board("seed0");

    // Start while busy is ignored
    build_model(16'h0001);
    run_start(16'h0001, 20, 0, -1);
    chk(K_LAT, 0, 71, "latency_midstart");
    chk(K_BUSYCNT, 0, 71, "busy_cycles_midstart");
    check_board("midstart");

    // Clear rules: same-cycle read sees the old value
    @(posedge clock);
    #1;
    clear_en   = 1'b1;
    clear_addr = 6'd5;
    chk(K_RD, 5, model[5], "rd_during_clear");
    @(posedge clock);
    #1;
    clear_en = 1'b0;
    chk(K_RD, 5, EMPTY, "rd_after_clear");
    chk(K_LEFT, 0, 35, "left_after_clear5");
    pulse_clear(5);
    chk(K_LEFT, 0, 35, "left_reclear5");
    pulse_clear(40);
    chk(K_LEFT, 0, 35, "left_clear40");
    chk(K_ALLCLR, 0, 0, "all_cleared_partial");

    // Start and clear in the same DONE cycle: start wins
    run_start(16'h0001, 0, 0, 3);
    chk(K_LAT, 0, 71, "latency_restart");
    chk(K_LEFT, 0, 36, "left_restart");
    chk(K_RD, 3, model[3], "start_beats_clear");
    chk(K_RD, 5, model[5], "restart_restores5");

    // Clear everything
    for (int p = 0; p < 36; p++) pulse_clear(p);
    chk(K_LEFT, 0, 0, "left_all_cleared");
    chk(K_ALLCLR, 0, 1, "all_cleared");
    chk(K_READY, 0, 1, "ready_all_cleared");
    chk(K_RD, 17, EMPTY, "rd_all_cleared");

    // Reset mid-shuffle
    run_start(16'h0001, 0, 50, -1);
    chk(K_BUSY, 0, 0, "midrst_busy");
    chk(K_READY, 0, 0, "midrst_ready");
    chk(K_LEFT, 0, 0, "midrst_left");
    for (int a = 0; a < 36; a++) chk(K_RD, a, EMPTY, $sformatf("midrst_rd%0d", a));
    build_model(16'h1234);
    run_start(16'h1234, 0, 0, -1);
    chk(K_LAT, 0, 71, "latency_after_reset");
    chk(K_LEFT, 0, 36, "left_after_reset");
    check_board("after_reset");

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/card_board_shuffler.md
Name: card_board_shuffler

Overview:
Writer side of the 6x6 card board. It fills a 36-entry board with 18 value pairs and shuffles it with an LFSR-driven Fisher-Yates pass. It then serves random-access reads of card values to the card comparator, addressed by the 0..35 board position the comparator already uses. The comparator writes back "clear" commands for matched cards; the block tracks how many cards remain.

Parameters:
NUM_CARDS, 36, board entries (6x6)
DATA_W, 5, card value width; values 0..17 valid
ADDR_W, 6, position width
LFSR_SEED, 16'hACE1, substitute seed when seed_in==0; value after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse: load seed, fill and shuffle board
seed_in  in  16  seed sampled with start
rd_addr  in  ADDR_W  board position to read
rd_data  out  DATA_W  card value at rd_addr (combinational)
clear_en  in  1  remove card at clear_addr
clear_addr  in  ADDR_W  position to clear
busy  out  1  fill/shuffle in progress
ready  out  1  board valid, reads/clears honoured
cards_left  out  6  uncleared cards on board
all_cleared  out  1  ready && cards_left==0

Behaviour:
- EMPTY = 5'h1F marks a removed or invalid card.
- Reset (any state, including mid-shuffle):
  - state=IDLE, all 36 entries=EMPTY, lfsr=LFSR_SEED.
  - busy=0, ready=0, cards_left=0, all_cleared=0.
- FSM states: IDLE, FILL, SHUFFLE, DONE.
- IDLE:
  - start=1 -> FILL; i=0; lfsr=(seed_in==0)?LFSR_SEED:seed_in.
- FILL:
  - one write per cycle, board[i]=i>>1, so the board holds 0,0,1,1,...,17,17.
  - i=35 written -> SHUFFLE with i=35.
- SHUFFLE:
  - one swap per cycle: j=(lfsr[7:0]*(i+1))>>8, a 14-bit product giving j in 0..i.
  - swap board[i] and board[j]; j==i is a no-op.
  - lfsr advances one step, Galois 16-bit, mask 16'hB400, shift right.
  - i decrements; after the i=1 swap -> DONE and cards_left=36.
- DONE:
  - start=1 -> restart: behaves exactly as start from IDLE (board overwritten by FILL).
- Latency: start sampled at edge E0. FILL writes on E1..E36, swaps on E37..E71. ready=1 after E71, i.e. 71 cycles after start is sampled. Fixed; no data dependence.
- busy=1 in FILL and SHUFFLE. ready=1 only in DONE. Both registered.
- start while busy: ignored. Shuffle is unaffected and the latency is unchanged.
- rd_data:
  - board[rd_addr] when ready and rd_addr<36.
  - otherwise EMPTY, including during busy and in IDLE.
- Clear:
  - honoured only when ready && clear_en && clear_addr<36 && board[clear_addr]!=EMPTY.
  - write EMPTY at the next edge; cards_left decrements by 1.
  - Clear of an already-EMPTY or out-of-range position: no change.
  - clear_en outside DONE: ignored.
- Only one clear per cycle. Start and clear in the same DONE cycle: start wins and the clear is dropped.
- Read of a position being cleared in the same cycle returns the old value; EMPTY from the next cycle.
- Invariant in DONE: every value 0..17 appears exactly 0 or 2 times, unless a single card of a pair was cleared.

Decomposition:
- Shared package card_pkg:
  - EMPTY_CARD, NUM_CARDS, NUM_PAIRS=18.
  - card_t (logic [4:0]), pos_t (logic [5:0]).
  - board_state_t enum {IDLE, FILL, SHUFFLE, DONE}.
  - The comparator imports the same package.
- Sub-module lfsr16:
  - ports: clock, reset, load, load_val, step, q[15:0].
  - Galois, mask 16'hB400; reset value LFSR_SEED; load has priority over step.
- Board storage: a 36x5 register array inside card_board_shuffler (single-cycle swap needs two reads and two writes).

Test Plan:
- Reset state: after reset, all rd_addr 0..63 read 5'h1F; ready=0, busy=0, cards_left=0.
- Fill/shuffle timing and contents: start with seed_in=16'h0001 -> busy=1 for exactly 71 cycles, ready rises on cycle 71. Histogram of positions 0..35 shows each of 0..17 exactly twice; cards_left=36. Compare the board against a reference model using the same LFSR/j formula.
- Determinism: repeat with seed 16'h0001 -> identical board. Seed 16'h1234 -> board differs. seed_in=0 -> board identical to seed 16'hACE1.
- Clear rules: in DONE, clear addr 5 -> rd_data(5)=1F, cards_left=35. Clear addr 5 again -> stays 35. Clear addr 40 -> stays 35. Clear all 36 positions -> all_cleared=1.
- Start while busy: start pulse at cycle 20 of a shuffle is ignored; ready still at cycle 71 and the board matches the single-start model. Start in DONE -> full restart, cards_left restored to 36.
- Reset mid-shuffle: assert reset at cycle 50 -> next cycle IDLE, all reads 1F, busy=0. A subsequent start completes normally in 71 cycles.
